// File: rtl/mips_store_buffer_if.sv
// mips_store_buffer_if: core store/load port plus memory drain port of the store buffer
interface mips_store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    logic                     memwrite;
    logic [AW-1:0]            dataadr;
    logic [DW-1:0]            writedata;
    logic                     stall;
    logic                     fwd_hit;
    logic [DW-1:0]            fwd_data;
    logic                     mem_we;
    logic [AW-1:0]            mem_addr;
    logic [DW-1:0]            mem_wdata;
    logic                     mem_ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     align_err;
    modport master (
        output memwrite, dataadr, writedata, mem_ready,
        input  stall, fwd_hit, fwd_data, mem_we, mem_addr, mem_wdata, count, align_err
    );
    modport slave (
        input  memwrite, dataadr, writedata, mem_ready,
        output stall, fwd_hit, fwd_data, mem_we, mem_addr, mem_wdata, count, align_err
    );
endinterface

// File: rtl/mips_store_buffer.sv
// mips_store_buffer: in-order posted-write FIFO with youngest-entry coalescing and load forwarding
module mips_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input logic                clk,
    input logic                reset,
    mips_store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d, yng;
    logic [PW:0]      count_q, count_d;
    logic             align_q, align_d;
    logic             aligned, full, pop, coalesce, push, alloc, hit;
    logic [DW-1:0]    fdata;

    always_comb begin
        yng      = tail_q - PW'(1);
        aligned  = sb.dataadr[1:0] == 2'b00;
        full     = count_q == FULL_CNT;
        pop      = valid_q[head_q] && sb.mem_ready;
        // a lone entry leaving this cycle cannot absorb a merge, so the store allocates behind it
        coalesce = sb.memwrite && aligned && count_q != '0
                   && addr_q[yng][AW-1:2] == sb.dataadr[AW-1:2]
                   && !(count_q == (PW+1)'(1) && pop);
        push     = sb.memwrite && aligned && (!full || coalesce);
        alloc    = push && !coalesce;
        head_d   = pop ? head_q + PW'(1) : head_q;
        tail_d   = alloc ? tail_q + PW'(1) : tail_q;
        count_d  = count_q + (PW+1)'(alloc) - (PW+1)'(pop);
        align_d  = align_q || (sb.memwrite && !aligned);
    end

    always_comb begin
        hit   = 1'b0;
        fdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[head_q + PW'(i)] && addr_q[head_q + PW'(i)][AW-1:2] == sb.dataadr[AW-1:2]) begin
                hit   = 1'b1;
                fdata = data_q[head_q + PW'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            align_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            align_q <= align_d;
            if (pop) valid_q[head_q] <= 1'b0;
            if (alloc) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= sb.dataadr;
                data_q[tail_q]  <= sb.writedata;
            end
            if (coalesce) data_q[yng] <= sb.writedata;
        end
    end

    assign sb.stall     = sb.memwrite && aligned && full && !coalesce;
    assign sb.fwd_hit   = hit && !sb.memwrite;
    assign sb.fwd_data  = sb.fwd_hit ? fdata : '0;
    assign sb.mem_we    = valid_q[head_q];
    assign sb.mem_addr  = valid_q[head_q] ? addr_q[head_q] : '0;
    assign sb.mem_wdata = valid_q[head_q] ? data_q[head_q] : '0;
    assign sb.count     = count_q;
    assign sb.align_err = align_q;
endmodule

// File: tb/tb_mips_store_buffer.sv
// tb_mips_store_buffer: directed vector table plus random traffic against a queue-based model
module tb_mips_store_buffer;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mips_store_buffer_if #(.DEPTH(DEPTH), .AW(32), .DW(32)) sb();
    mips_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (.clk(clk), .reset(reset), .sb(sb.slave));

    typedef struct {
        logic mw; logic [31:0] a; logic [31:0] d; logic rdy;
        logic stall; int cnt; logic we; logic [31:0] ma; logic [31:0] md; logic hit; logic [31:0] fd;
    } vec_t;
    typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;

    ent_t mq[$];
    logic m_align = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    bit tab_on = 0;
    vec_t cur;
    vec_t tab[37];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        int n;
        bit al, pop, coal, e_stall, hit;
        logic [31:0] fd;
        sb.memwrite = mw; sb.dataadr = a; sb.writedata = d; sb.mem_ready = rdy;
        @(negedge clk);
        n = mq.size();
        al = a[1:0] == 2'b00;
        pop = n > 0 && rdy;
        coal = mw && al && n > 0 && mq[n-1].a[31:2] == a[31:2] && !(n == 1 && pop);
        e_stall = mw && al && n == DEPTH && !coal;
        hit = 0;
        fd = '0;
        if (!mw)
            for (int i = n - 1; i >= 0; i--)
                if (!hit && mq[i].a[31:2] == a[31:2]) begin hit = 1; fd = mq[i].d; end
        chk("m_stall", 32'(sb.stall), 32'(e_stall));
        chk("m_count", 32'(sb.count), 32'(n));
        chk("m_we", 32'(sb.mem_we), 32'(n > 0));
        if (n > 0) begin
            chk("m_addr", sb.mem_addr, mq[0].a);
            chk("m_wdata", sb.mem_wdata, mq[0].d);
        end
        chk("m_hit", 32'(sb.fwd_hit), 32'(hit));
        chk("m_fdata", sb.fwd_data, fd);
        chk("m_align", 32'(sb.align_err), 32'(m_align));
        if (tab_on) begin
            chk("t_stall", 32'(sb.stall), 32'(cur.stall));
            chk("t_count", 32'(sb.count), 32'(cur.cnt));
            chk("t_we", 32'(sb.mem_we), 32'(cur.we));
            if (cur.we) begin
                chk("t_addr", sb.mem_addr, cur.ma);
                chk("t_wdata", sb.mem_wdata, cur.md);
            end
            chk("t_hit", 32'(sb.fwd_hit), 32'(cur.hit));
            chk("t_fdata", sb.fwd_data, cur.fd);
        end
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (mw && !al) m_align = 1'b1;
        else if (mw && !e_stall) begin
            if (coal) mq[mq.size()-1].d = d;
            else mq.push_back('{a: a, d: d});
        end
        #1;
    endtask

    function automatic vec_t mk(logic mw, int a, int d, logic rdy, logic st, int c, logic we,
                                int ma, int md, logic h, int f);
        mk = '{mw, 32'(a), 32'(d), rdy, st, c, we, 32'(ma), 32'(md), h, 32'(f)};
    endfunction

    initial begin
        tab[0]  = mk(1, 80, 7, 1,  0, 0, 0, 0, 0, 0, 0);
        tab[1]  = mk(1, 84, 7, 1,  0, 1, 1, 80, 7, 0, 0);
        tab[2]  = mk(0, 0, 0, 1,   0, 1, 1, 84, 7, 0, 0);
        tab[3]  = mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        tab[4]  = mk(1, 0, 10, 0,  0, 0, 0, 0, 0, 0, 0);
        tab[5]  = mk(1, 4, 11, 0,  0, 1, 1, 0, 10, 0, 0);
        tab[6]  = mk(1, 8, 12, 0,  0, 2, 1, 0, 10, 0, 0);
        tab[7]  = mk(1, 12, 13, 0, 0, 3, 1, 0, 10, 0, 0);
        tab[8]  = mk(1, 16, 14, 0, 1, 4, 1, 0, 10, 0, 0);
        tab[9]  = mk(1, 16, 14, 1, 1, 4, 1, 0, 10, 0, 0);
        tab[10] = mk(1, 16, 14, 1, 0, 3, 1, 4, 11, 0, 0);
        tab[11] = mk(0, 16, 0, 1,  0, 3, 1, 8, 12, 1, 14);
        tab[12] = mk(0, 0, 0, 1,   0, 2, 1, 12, 13, 0, 0);
        tab[13] = mk(0, 0, 0, 1,   0, 1, 1, 16, 14, 0, 0);
        tab[14] = mk(1, 40, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        tab[15] = mk(1, 40, 2, 0,  0, 1, 1, 40, 1, 0, 0);
        tab[16] = mk(0, 40, 0, 0,  0, 1, 1, 40, 2, 1, 2);
        tab[17] = mk(1, 44, 3, 0,  0, 1, 1, 40, 2, 0, 0);
        tab[18] = mk(1, 48, 4, 0,  0, 2, 1, 40, 2, 0, 0);
        tab[19] = mk(1, 52, 5, 0,  0, 3, 1, 40, 2, 0, 0);
        tab[20] = mk(1, 52, 6, 0,  0, 4, 1, 40, 2, 0, 0);
        tab[21] = mk(0, 52, 0, 0,  0, 4, 1, 40, 2, 1, 6);
        tab[22] = mk(0, 0, 0, 1,   0, 4, 1, 40, 2, 0, 0);
        tab[23] = mk(0, 0, 0, 1,   0, 3, 1, 44, 3, 0, 0);
        tab[24] = mk(0, 0, 0, 1,   0, 2, 1, 48, 4, 0, 0);
        tab[25] = mk(0, 0, 0, 1,   0, 1, 1, 52, 6, 0, 0);
        tab[26] = mk(1, 60, 9, 0,  0, 0, 0, 0, 0, 0, 0);
        tab[27] = mk(1, 64, 3, 0,  0, 1, 1, 60, 9, 0, 0);
        tab[28] = mk(1, 60, 5, 0,  0, 2, 1, 60, 9, 0, 0);
        tab[29] = mk(0, 60, 0, 0,  0, 3, 1, 60, 9, 1, 5);
        tab[30] = mk(0, 68, 0, 0,  0, 3, 1, 60, 9, 0, 0);
        tab[31] = mk(0, 0, 0, 1,   0, 3, 1, 60, 9, 0, 0);
        tab[32] = mk(0, 0, 0, 1,   0, 2, 1, 64, 3, 0, 0);
        tab[33] = mk(1, 60, 8, 1,  0, 1, 1, 60, 5, 0, 0);
        tab[34] = mk(0, 0, 0, 0,   0, 1, 1, 60, 8, 0, 0);
        tab[35] = mk(0, 0, 0, 1,   0, 1, 1, 60, 8, 0, 0);
        tab[36] = mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);

        sb.memwrite = 1'b0; sb.dataadr = '0; sb.writedata = '0; sb.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 32'(sb.mem_we), 0);
        chk("rst_count", 32'(sb.count), 0);
        chk("rst_stall", 32'(sb.stall), 0);
        chk("rst_hit", 32'(sb.fwd_hit), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) step(0, 0, 0, 1);

        tab_on = 1;
        for (int i = 0; i < 37; i++) begin
            cur = tab[i];
            step(cur.mw, cur.a, cur.d, cur.rdy);
        end
        tab_on = 0;

        step(1, 82, 5, 0);
        repeat (3) step(0, 82, 0, 1);
        chk("align_sticky", 32'(sb.align_err), 1);
        chk("align_no_entry", 32'(sb.count), 0);

        step(1, 100, 1, 0);
        step(1, 104, 2, 0);
        step(1, 108, 3, 0);
        step(1, 112, 4, 0);
        step(0, 0, 0, 1);
        chk("pre_rst_count", 32'(sb.count), 3);
        reset = 1'b1; sb.memwrite = 1'b0; sb.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        m_align = 1'b0;
        repeat (4) step(0, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 5) * 4);
            if ($urandom_range(0, 15) == 0) a = a + 32'($urandom_range(1, 3));
            step(1'($urandom_range(0, 1)), a, $urandom,
                 i < 200 ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
